pl_reg_mw_skid: RTL and testbench

PL_REG_MW_SKID -- requirements
Module: pl_reg_mw_skid

---
 rtl/pl_reg_mw_skid_pkg.sv | 23 ++
 rtl/pl_entry.sv | 48 ++++
 rtl/pl_reg_mw_skid.sv | 137 +++++++++++++
 tb/tb_pl_reg_mw_skid.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_reg_mw_skid_pkg.sv
// Shared types for the M->W pipeline register: thread-count helper and the
// payload layout at the default configuration (also the entry's default type).
package pl_reg_mw_skid_pkg;

    localparam int MW_ADDRESS_WIDTH = 32;
    localparam int MW_DATA_WIDTH    = 32;
    localparam int MW_BITS_THREADS  = 3;

    function automatic int nthreads(input int bits_threads);
        return 1 << bits_threads;
    endfunction

    typedef struct packed {
        logic                        reg_write;
        logic [1:0]                  result_src;
        logic [MW_DATA_WIDTH-1:0]    alu_result;
        logic [MW_DATA_WIDTH-1:0]    read_data;
        logic [4:0]                  rd;
        logic [MW_ADDRESS_WIDTH-1:0] pc_plus4;
        logic [MW_BITS_THREADS-1:0]  tid;
    } mw_payload_t;

endpackage

// File: rtl/pl_entry.sv
// One pipeline slot: a valid bit plus payload with clear > load > kill priority.
// Kill drops the valid bit only, so the payload keeps showing its last value.
module pl_entry
    import pl_reg_mw_skid_pkg::*;
#(
    parameter type T = mw_payload_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic kill_i,
    input  T     data_i,
    output logic valid_o,
    output T     data_o
);

    logic valid_q, valid_d;
    T     data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pl_reg_mw_skid.sv
// M->W pipeline register with a skid entry: full throughput, ready_o purely
// registered, per-thread flush and a saturating count of flushed beats.
module pl_reg_mw_skid
    import pl_reg_mw_skid_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BITS_THREADS  = 3,
    localparam int NTHREADS     = nthreads(BITS_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     flush_i,
    input  logic [NTHREADS-1:0]      flush_mask_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     reg_write_i,
    input  logic [1:0]               result_src_i,
    input  logic [DATA_WIDTH-1:0]    alu_result_i,
    input  logic [DATA_WIDTH-1:0]    read_data_i,
    input  logic [4:0]               rd_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_i,
    input  logic [BITS_THREADS-1:0]  tid_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     reg_write_o,
    output logic [1:0]               result_src_o,
    output logic [DATA_WIDTH-1:0]    alu_result_o,
    output logic [DATA_WIDTH-1:0]    read_data_o,
    output logic [4:0]               rd_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic [BITS_THREADS-1:0]  tid_o,
    output logic [1:0]               occupancy_o,
    output logic [15:0]              kill_count_o
);

    typedef struct packed {
        logic                     reg_write;
        logic [1:0]               result_src;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    read_data;
        logic [4:0]               rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        logic [BITS_THREADS-1:0]  tid;
    } payload_t;

    payload_t in_pl, out_pl, skid_pl, out_d;
    logic     out_v, skid_v;
    logic     kill_out, kill_skid, kill_in;
    logic     accept, out_live, skid_live, in_live, out_free;
    logic     out_load, out_kill, skid_load, skid_kill;
    logic [1:0]  n_kill;
    logic [16:0] kill_sum;
    logic [15:0] kill_cnt_q, kill_cnt_d;

    assign in_pl = '{reg_write:  reg_write_i,
                     result_src: result_src_i,
                     alu_result: alu_result_i,
                     read_data:  read_data_i,
                     rd:         rd_i,
                     pc_plus4:   pc_plus4_i,
                     tid:        tid_i};

    assign ready_o = !skid_v;

    // Kills are resolved first; the move rules below only see survivors, so a
    // surviving SKID refills a killed OUT on the same edge.
    always_comb begin
        kill_out  = flush_i && flush_mask_i[out_pl.tid];
        kill_skid = flush_i && flush_mask_i[skid_pl.tid];
        kill_in   = flush_i && valid_i && flush_mask_i[tid_i];
        accept    = valid_i && ready_o;
        out_live  = out_v && !kill_out;
        skid_live = skid_v && !kill_skid;
        in_live   = accept && !kill_in;
        out_free  = !out_live || ready_i;
        out_load  = out_free && (skid_live || in_live);
        out_kill  = out_free && !out_load;
        out_d     = skid_live ? skid_pl : in_pl;
        skid_load = !out_free && in_live;
        skid_kill = !skid_load && (out_free || !skid_live);
    end

    pl_entry #(.T(payload_t)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .load_i  (out_load),
        .kill_i  (out_kill),
        .data_i  (out_d),
        .valid_o (out_v),
        .data_o  (out_pl)
    );

    pl_entry #(.T(payload_t)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .load_i  (skid_load),
        .kill_i  (skid_kill),
        .data_i  (in_pl),
        .valid_o (skid_v),
        .data_o  (skid_pl)
    );

    // A clear wins over flush, so nothing it discards is counted.
    always_comb begin
        n_kill = 2'd0;
        if (!clr) begin
            n_kill = {1'b0, out_v && kill_out} + {1'b0, skid_v && kill_skid}
                   + {1'b0, kill_in};
        end
        kill_sum   = {1'b0, kill_cnt_q} + {15'd0, n_kill};
        kill_cnt_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_cnt_q <= 16'd0;
        end else begin
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign valid_o      = out_v;
    assign reg_write_o  = out_pl.reg_write && out_v;
    assign result_src_o = out_pl.result_src;
    assign alu_result_o = out_pl.alu_result;
    assign read_data_o  = out_pl.read_data;
    assign rd_o         = out_pl.rd;
    assign pc_plus4_o   = out_pl.pc_plus4;
    assign tid_o        = out_pl.tid;
    assign occupancy_o  = {1'b0, out_v} + {1'b0, skid_v};
    assign kill_count_o = kill_cnt_q;

endmodule

// File: tb/tb_pl_reg_mw_skid.sv
// Bench for pl_reg_mw_skid at DATA_WIDTH=64, BITS_THREADS=4: an ordered-queue
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_pl_reg_mw_skid;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BT = 4;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr, flush_i, valid_i, ready_i, reg_write_i;
    logic [NT-1:0] flush_mask_i;
    logic [1:0]    result_src_i;
    logic [DW-1:0] alu_result_i, read_data_i;
    logic [4:0]    rd_i;
    logic [AW-1:0] pc_plus4_i;
    logic [BT-1:0] tid_i;
    logic          ready_o, valid_o, reg_write_o;
    logic [1:0]    result_src_o, occupancy_o;
    logic [DW-1:0] alu_result_o, read_data_o;
    logic [4:0]    rd_o;
    logic [AW-1:0] pc_plus4_o;
    logic [BT-1:0] tid_o;
    logic [15:0]   kill_count_o;

    always #5 clk = ~clk;

    pl_reg_mw_skid #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BITS_THREADS(BT)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .flush_i(flush_i),
        .flush_mask_i(flush_mask_i), .valid_i(valid_i), .ready_o(ready_o),
        .reg_write_i(reg_write_i), .result_src_i(result_src_i),
        .alu_result_i(alu_result_i), .read_data_i(read_data_i), .rd_i(rd_i),
        .pc_plus4_i(pc_plus4_i), .tid_i(tid_i), .valid_o(valid_o),
        .ready_i(ready_i), .reg_write_o(reg_write_o), .result_src_o(result_src_o),
        .alu_result_o(alu_result_o), .read_data_o(read_data_o), .rd_o(rd_o),
        .pc_plus4_o(pc_plus4_o), .tid_o(tid_o), .occupancy_o(occupancy_o),
        .kill_count_o(kill_count_o)
    );

    typedef struct packed {
        logic          rw;
        logic [1:0]    rs;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata;
        logic [4:0]    rd;
        logic [AW-1:0] pc;
        logic [BT-1:0] tid;
    } beat_t;

    // Model: pipeline contents in acceptance order; front is what W sees.
    beat_t mq[$];
    beat_t last_b;
    int    kc;
    int    checks = 0;
    int    errors = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int n, input int tid);
        beat_t b;
        b.rw    = n[0];
        b.rs    = n[2:1];
        b.alu   = {32'hA000_0000 | 32'(n), 32'h1234_0000 | 32'(n)};
        b.rdata = {32'hD000_0000 | 32'(n), 32'h5555_0000 | 32'(n)};
        b.rd    = 5'(n + 1);
        b.pc    = 32'h0000_1000 + 32'(4 * n);
        b.tid   = BT'(tid);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        beat_t nq[$];
        beat_t ib;
        int    n_kill;
        bit    drain, acc;
        if (!rst_n) begin
            mq.delete();
            last_b = '0;
            kc     = 0;
        end else if (clr) begin
            mq.delete();
            last_b = '0;
        end else begin
            ib     = '{rw: reg_write_i, rs: result_src_i, alu: alu_result_i,
                       rdata: read_data_i, rd: rd_i, pc: pc_plus4_i, tid: tid_i};
            n_kill = 0;
            nq.delete();
            acc    = valid_i && (mq.size() < 2);
            drain  = ready_i && (mq.size() > 0) && !(flush_i && flush_mask_i[mq[0].tid]);
            foreach (mq[i]) begin
                if (flush_i && flush_mask_i[mq[i].tid]) n_kill++;
                else if (!(i == 0 && drain)) nq.push_back(mq[i]);
            end
            if (valid_i && flush_i && flush_mask_i[tid_i]) n_kill++;
            else if (acc) nq.push_back(ib);
            mq = nq;
            kc = (kc + n_kill > 65535) ? 65535 : kc + n_kill;
            if (mq.size() > 0) last_b = mq[0];
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("valid_o", valid_o, mq.size() > 0);
            chk("ready_o", ready_o, mq.size() < 2);
            chk("occupancy_o", occupancy_o, mq.size());
            chk("kill_count_o", kill_count_o, kc);
            chk("reg_write_o", reg_write_o, (mq.size() > 0) && last_b.rw);
            chk("result_src_o", result_src_o, last_b.rs);
            chk("alu_result_o", alu_result_o, last_b.alu);
            chk("read_data_o", read_data_o, last_b.rdata);
            chk("rd_o", rd_o, last_b.rd);
            chk("pc_plus4_o", pc_plus4_o, last_b.pc);
            chk("tid_o", tid_o, last_b.tid);
        end
    end

    task automatic drive(input beat_t b);
        valid_i      = 1'b1;
        reg_write_i  = b.rw;
        result_src_i = b.rs;
        alu_result_i = b.alu;
        read_data_i  = b.rdata;
        rd_i         = b.rd;
        pc_plus4_i   = b.pc;
        tid_i        = b.tid;
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int k0;

    initial begin
        rst_n = 1'b1; clr = 1'b0; flush_i = 1'b0; flush_mask_i = '0;
        ready_i = 1'b1; valid_i = 1'b0;
        drive(mk(99, 0)); idle();
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        step(); step();
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_ready", ready_o, 1'b1);
        chk("reset_kill", kill_count_o, 16'd0);
        rst_n = 1'b1;
        step();

        // Streaming: 8 beats back to back with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            drive(mk(i, i));
            step();
            chk("stream_occ", occupancy_o <= 2'd1, 1'b1);
            chk("stream_tid", tid_o, 64'(i));
            if (i == 0) chk("stream_first_alu", alu_result_o, 64'hA000_0000_1234_0000);
        end
        idle(); step();
        chk("stream_empty", valid_o, 1'b0);

        // Stall: A lands in OUT, B in SKID, then both drain in order.
        ready_i = 1'b0;
        drive(mk(20, 3)); step();
        drive(mk(21, 4)); step();
        idle(); step();
        chk("stall_occ", occupancy_o, 2'd2);
        chk("stall_ready", ready_o, 1'b0);
        chk("stall_rd_A", rd_o, 5'd21);
        ready_i = 1'b1; step();
        chk("stall_rd_B", rd_o, 5'd22);
        chk("stall_ready_back", ready_o, 1'b1);
        step();
        chk("stall_drained", valid_o, 1'b0);

        // Flush of the OUT thread only: SKID survivor moves up without a bubble.
        ready_i = 1'b0;
        drive(mk(30, 2)); step();
        drive(mk(31, 5)); step();
        idle(); k0 = kill_count_o;
        flush_i = 1'b1; flush_mask_i = 16'h0004; step();
        flush_i = 1'b0;
        chk("flush1_tid", tid_o, 64'd5);
        chk("flush1_valid", valid_o, 1'b1);
        chk("flush1_kill", kill_count_o, 64'(k0 + 1));
        ready_i = 1'b1; step(); step();

        // Flush of both entries and the stalled incoming beat.
        ready_i = 1'b0;
        drive(mk(40, 1)); step();
        drive(mk(41, 1)); step();
        drive(mk(42, 1)); k0 = kill_count_o;
        flush_i = 1'b1; flush_mask_i = 16'h0002; step();
        flush_i = 1'b0; idle();
        chk("flush3_valid", valid_o, 1'b0);
        chk("flush3_kill", kill_count_o, 64'(k0 + 3));
        step();

        // Clear beats flush and an incoming beat.
        drive(mk(50, 6)); step();
        drive(mk(51, 6)); k0 = kill_count_o;
        clr = 1'b1; flush_i = 1'b1; flush_mask_i = '1; step();
        clr = 1'b0; flush_i = 1'b0; idle();
        chk("clr_occ", occupancy_o, 2'd0);
        chk("clr_alu", alu_result_o, 64'd0);
        chk("clr_kill", kill_count_o, 64'(k0));
        ready_i = 1'b1; step();

        // Mixed directed traffic: ready toggling and periodic partial flushes.
        for (int i = 0; i < 32; i++) begin
            ready_i = (i % 3) != 1;
            if (i % 4 != 3) drive(mk(60 + i, i % 4)); else idle();
            flush_i      = (i % 5) == 4;
            flush_mask_i = 16'h0001 << (i % 4);
            step();
        end
        flush_i = 1'b0; idle(); ready_i = 1'b1; step(); step();

        // Asynchronous reset in the middle of a stall.
        ready_i = 1'b0;
        drive(mk(70, 9)); step();
        drive(mk(71, 10)); step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_ready", ready_o, 1'b1);
        chk("arst_occ", occupancy_o, 2'd0);
        chk("arst_kill", kill_count_o, 16'd0);
        chk("arst_payload", {alu_result_o, read_data_o} == '0 && pc_plus4_o == '0
                            && rd_o == '0 && tid_o == '0 && result_src_o == '0, 1'b1);
        step();
        rst_n = 1'b1;
        drive(mk(80, 7)); ready_i = 1'b1; step();
        idle();
        chk("release_accept", valid_o, 1'b1);
        chk("release_rd", rd_o, 5'd17);
        step();

        // Saturation: a killed incoming beat every cycle.
        ready_i = 1'b0; flush_i = 1'b1; flush_mask_i = '1;
        drive(mk(90, 11));
        for (int i = 0; i < 65540; i++) step();
        flush_i = 1'b0; idle();
        chk("kill_saturate", kill_count_o, 16'hFFFF);
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
